// File: rtl/sonar_pkg.sv
// sonar_pkg: shared types and defaults for the ultrasonic ranging engine.
//   sonar_state_t      - ranging FSM states
//   *_DEF              - parameter defaults for a 100 MHz ACLK
//   DIST_TIMEOUT_CODE  - distance reported on timeout (all ones, cast to DIST_W)
//   max3()             - helper for sizing the shared cycle counter
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } sonar_state_t;

  localparam int TRIG_CYCLES_DEF    = 1000;     // 10 us
  localparam int CYCLES_PER_CM_DEF  = 5800;     // 58 us per cm round trip
  localparam int TIMEOUT_CYCLES_DEF = 3800000;  // 38 ms
  localparam int HOLDOFF_CYCLES_DEF = 6000000;  // 60 ms
  localparam int DIST_W_DEF         = 16;

  // Wide all-ones; users truncate to their DIST_W.
  localparam logic [63:0] DIST_TIMEOUT_CODE = '1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// sonar_echo_sync: 2-flop synchroniser plus one edge-detect flop for
// asynchronous sensor pins. Rise/fall pulses are combinational from the
// flops and appear for one cycle, so a pin change is acted on by the
// consumer at the third clock edge after it.
//   ACLK, ARESETN  clock, async active-low reset
//   pin_i          raw asynchronous pins
//   echo_s_o       synchronised level
//   echo_rise_o    one-cycle rise pulse
//   echo_fall_o    one-cycle fall pulse
module sonar_echo_sync #(
  parameter int W = 1
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] echo_s_o,
  output logic [W-1:0] echo_rise_o,
  output logic [W-1:0] echo_fall_o
);

  logic [W-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign echo_s_o    = sync_q;
  assign echo_rise_o = sync_q & ~prev_q;
  assign echo_fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/sonar_ranger.sv
// sonar_ranger: HC-SR04 style ranging engine. Issues the trigger pulse,
// times the echo and converts its width to centimetres.
//   ACLK, ARESETN  clock, async active-low reset
//   start_i        one-shot measurement request (only honoured in IDLE)
//   cont_en_i      level: auto re-trigger after each holdoff
//   echo_i         raw echo pin (asynchronous)
//   trig_o         sensor trigger (registered)
//   busy_o         FSM not in IDLE
//   done_o         one-cycle pulse when distance_o/timeout_o update
//   timeout_o      last measurement timed out
//   distance_o     last distance in cm, all ones on timeout
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int DIST_W         = DIST_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start_i,
  input  logic              cont_en_i,
  input  logic              echo_i,
  output logic              trig_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [DIST_W-1:0] distance_o
);

  // One cycle counter is shared by TRIG, WAIT_RISE, MEASURE and HOLDOFF.
  localparam int CNT_W = $clog2(max3(TRIG_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES) + 1);
  localparam int SUB_W = $clog2(CYCLES_PER_CM + 1);

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HO_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0] DIST_TO   = DIST_W'(DIST_TIMEOUT_CODE);

  sonar_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic              trig_q, trig_d;
  logic              done_q, done_d;
  logic              to_q, to_d;
  logic [DIST_W-1:0] dist_q, dist_d;

  logic echo_s, echo_rise, echo_fall;

  sonar_echo_sync #(.W(1)) u_echo_sync (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .pin_i       (echo_i),
    .echo_s_o    (echo_s),
    .echo_rise_o (echo_rise),
    .echo_fall_o (echo_fall)
  );

  // Per-cycle MEASURE tick. The fall cycle itself is counted too, so
  // committing the ticked value makes distance = floor(echo_width / CPC).
  logic              sub_wrap;
  logic [SUB_W-1:0]  sub_tick;
  logic [DIST_W-1:0] cm_tick;

  assign sub_wrap = (sub_q == SUB_LAST);
  assign sub_tick = sub_wrap ? '0 : sub_q + SUB_W'(1);
  assign cm_tick  = (sub_wrap && cm_q != DIST_TO) ? cm_q + DIST_W'(1) : cm_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    trig_d  = trig_q;
    done_d  = 1'b0;
    to_d    = to_q;
    dist_d  = dist_q;

    case (state_q)
      IDLE: begin
        if (start_i || cont_en_i) begin
          state_d = TRIG;
          trig_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      TRIG: begin
        // Echo edges here are ignored; counters held clear.
        sub_d = '0;
        cm_d  = '0;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          trig_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      WAIT_RISE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (echo_rise) begin
          state_d = MEASURE;
          cnt_d   = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          done_d  = 1'b1;
          to_d    = 1'b1;
          dist_d  = DIST_TO;
        end
      end

      MEASURE: begin
        cnt_d = cnt_q + CNT_W'(1);
        sub_d = sub_tick;
        cm_d  = cm_tick;
        if (echo_fall) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          done_d  = 1'b1;
          to_d    = 1'b0;
          dist_d  = cm_tick;
        end else if (cnt_q == TO_LAST) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          done_d  = 1'b1;
          to_d    = 1'b1;
          dist_d  = DIST_TO;
        end
      end

      HOLDOFF: begin
        // A sensor that aborted with echo stuck high keeps restarting the gap.
        if (echo_s) begin
          cnt_d = '0;
        end else if (cnt_q == HO_LAST) begin
          cnt_d = '0;
          if (cont_en_i) begin
            state_d = TRIG;
            trig_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        trig_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      to_q    <= to_d;
      dist_q  <= dist_d;
    end
  end

  assign trig_o     = trig_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign timeout_o  = to_q;
  assign distance_o = dist_q;

endmodule

// File: tb/tb_sonar_ranger.sv
module tb_sonar_ranger;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic start_i = 1'b0, cont_en_i = 1'b0, echo_i = 1'b0;
  logic trig_o, busy_o, done_o, timeout_o;
  logic [7:0] distance_o;

  logic start2 = 1'b0, cont2 = 1'b0, echo2 = 1'b0;
  logic trig2, busy2, done2, to2;
  logic [3:0] dist2;

  int checks = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  sonar_ranger #(.TRIG_CYCLES(10), .CYCLES_PER_CM(4), .TIMEOUT_CYCLES(200),
                 .HOLDOFF_CYCLES(50), .DIST_W(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start_i(start_i), .cont_en_i(cont_en_i),
    .echo_i(echo_i), .trig_o(trig_o), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .distance_o(distance_o));

  sonar_ranger #(.TRIG_CYCLES(10), .CYCLES_PER_CM(4), .TIMEOUT_CYCLES(200),
                 .HOLDOFF_CYCLES(50), .DIST_W(4)) dut_sat (
    .ACLK(ACLK), .ARESETN(ARESETN), .start_i(start2), .cont_en_i(cont2),
    .echo_i(echo2), .trig_o(trig2), .busy_o(busy2), .done_o(done2),
    .timeout_o(to2), .distance_o(dist2));

  // Trigger-rise monitor for continuous-mode spacing.
  int cyc_cnt = 0;
  int rise_cnt = 0;
  int rise_cyc [16];
  logic trig_prev = 1'b0;
  always @(posedge ACLK) begin
    #2;
    cyc_cnt++;
    if (trig_o === 1'b1 && trig_prev !== 1'b1) begin
      rise_cyc[rise_cnt % 16] = cyc_cnt;
      rise_cnt++;
    end
    trig_prev = trig_o;
  end

  task automatic cyc(input int k);
    repeat (k) begin @(posedge ACLK); #1; end
  endtask

  task automatic pulse_start;
    start_i = 1'b1; cyc(1); start_i = 1'b0;
  endtask

  task automatic wait_trig_fall(output int n);
    n = 0;
    while (trig_o === 1'b1 && n < 1000) begin cyc(1); n++; end
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (done_o !== 1'b1 && n < lim) begin cyc(1); n++; end
  endtask

  task automatic wait_idle(input int lim, output int n);
    n = 0;
    while (busy_o === 1'b1 && n < lim) begin cyc(1); n++; end
  endtask

  task automatic test_reset;
    cyc(2);
    checks++; if (trig_o !== 1'b0) begin failures++; $display("FAIL reset_trig got=%b want=0", trig_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_o); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b want=0", timeout_o); end
    checks++; if (distance_o !== 8'd0) begin failures++; $display("FAIL reset_dist got=%0d want=0", distance_o); end
    checks++; if (dist2 !== 4'd0) begin failures++; $display("FAIL reset_dist_sat got=%0d want=0", dist2); end
    ARESETN = 1'b1;
    cyc(2);
  endtask

  task automatic test_nominal;
    int n;
    pulse_start();
    wait_trig_fall(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL nom_trig_len got=%0d want=10", n); end
    cyc(20); echo_i = 1'b1; cyc(40); echo_i = 1'b0;
    wait_done(20, n);
    checks++; if (done_o !== 1'b1 || n !== 3) begin failures++; $display("FAIL nom_done got=%b lat=%0d want=1 lat=3", done_o, n); end
    checks++; if (distance_o !== 8'd10) begin failures++; $display("FAIL nom_dist got=%0d want=10", distance_o); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL nom_timeout got=%b want=0", timeout_o); end
    cyc(1);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL nom_done_pulse got=%b want=0", done_o); end
    n = 1;
    while (busy_o === 1'b1 && n < 200) begin cyc(1); n++; end
    checks++; if (n !== 50) begin failures++; $display("FAIL nom_holdoff got=%0d want=50", n); end
  endtask

  task automatic test_no_echo;
    int n;
    pulse_start();
    wait_trig_fall(n);
    wait_done(400, n);
    checks++; if (done_o !== 1'b1 || n !== 200) begin failures++; $display("FAIL noecho_done got=%b lat=%0d want=1 lat=200", done_o, n); end
    checks++; if (distance_o !== 8'hFF) begin failures++; $display("FAIL noecho_dist got=%0h want=ff", distance_o); end
    checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL noecho_timeout got=%b want=1", timeout_o); end
    wait_idle(200, n);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL noecho_idle got=%b want=0", busy_o); end
  endtask

  task automatic test_stuck;
    int n;
    pulse_start();
    wait_trig_fall(n);
    cyc(5); echo_i = 1'b1;
    wait_done(400, n);
    checks++; if (done_o !== 1'b1 || n !== 203) begin failures++; $display("FAIL stuck_done got=%b lat=%0d want=1 lat=203", done_o, n); end
    checks++; if (distance_o !== 8'hFF) begin failures++; $display("FAIL stuck_dist got=%0h want=ff", distance_o); end
    checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL stuck_timeout got=%b want=1", timeout_o); end
    cyc(60);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL stuck_holdoff_extend got=%b want=1", busy_o); end
    echo_i = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 200) begin cyc(1); n++; end
    checks++; if (n !== 52) begin failures++; $display("FAIL stuck_holdoff_len got=%0d want=52", n); end
    pulse_start();
    wait_trig_fall(n);
    cyc(5); echo_i = 1'b1; cyc(30); echo_i = 1'b0;
    wait_done(20, n);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL stuck_next_done got=%b want=1", done_o); end
    checks++; if (distance_o !== 8'd7) begin failures++; $display("FAIL stuck_next_dist got=%0d want=7", distance_o); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL stuck_next_timeout got=%b want=0", timeout_o); end
    wait_idle(200, n);
  endtask

  task automatic test_reset_mid;
    int n;
    pulse_start();
    cyc(3);
    #2 ARESETN = 1'b0;
    #1;
    checks++; if (trig_o !== 1'b0) begin failures++; $display("FAIL rmid_trig got=%b want=0", trig_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", busy_o); end
    checks++; if (distance_o !== 8'd0) begin failures++; $display("FAIL rmid_dist got=%0d want=0", distance_o); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL rmid_timeout got=%b want=0", timeout_o); end
    cyc(2);
    ARESETN = 1'b1;
    cyc(1);
    pulse_start();
    wait_trig_fall(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL rmid_trig_len got=%0d want=10", n); end
    wait_idle(400, n);
  endtask

  task automatic test_continuous;
    int n, r0, w, want;
    int widths [3] = '{16, 24, 3};
    int dists  [3] = '{4, 6, 0};
    r0 = rise_cnt;
    cont_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = widths[i];
      want = dists[i];
      n = 0;
      while (trig_o !== 1'b1 && n < 200) begin cyc(1); n++; end
      start_i = 1'b1; cyc(1); start_i = 1'b0;
      wait_trig_fall(n);
      cyc(5); echo_i = 1'b1; cyc(w); echo_i = 1'b0;
      pulse_start();
      wait_done(20, n);
      if (i == 2) cont_en_i = 1'b0;
      checks++; if (done_o !== 1'b1 || distance_o !== 8'(want)) begin failures++; $display("FAIL cont_dist%0d got=%0d done=%b want=%0d", i, distance_o, done_o, want); end
      checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL cont_timeout%0d got=%b want=0", i, timeout_o); end
    end
    wait_idle(200, n);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL cont_stop got=%b want=0", busy_o); end
    checks++; if (rise_cnt - r0 !== 3) begin failures++; $display("FAIL cont_rises got=%0d want=3", rise_cnt - r0); end
    for (int i = 1; i < 3; i++) begin
      n = rise_cyc[(r0 + i) % 16] - rise_cyc[(r0 + i - 1) % 16];
      checks++; if (n < 50) begin failures++; $display("FAIL cont_spacing%0d got=%0d want>=50", i, n); end
    end
  endtask

  task automatic test_saturation;
    int n;
    start2 = 1'b1; cyc(1); start2 = 1'b0;
    n = 0;
    while (trig2 === 1'b1 && n < 100) begin cyc(1); n++; end
    cyc(5); echo2 = 1'b1; cyc(100); echo2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 20) begin cyc(1); n++; end
    checks++; if (done2 !== 1'b1) begin failures++; $display("FAIL sat_done got=%b want=1", done2); end
    checks++; if (dist2 !== 4'd15) begin failures++; $display("FAIL sat_dist got=%0d want=15", dist2); end
    checks++; if (to2 !== 1'b0) begin failures++; $display("FAIL sat_timeout got=%b want=0", to2); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_no_echo();
    test_stuck();
    test_reset_mid();
    test_continuous();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
